// File: rtl/smol_fetch_unit.sv
// SmolCore fetch stage: PC, credit-limited imem requests, in-order responses into a prefetch FIFO.
// Define SMOL_FETCH_BYPASS_EN to forward a response straight to the decoder when the FIFO is empty.
module smol_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic          r_run;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_inflight, r_drop, r_cnt;
  logic [AW-1:0] r_rd, r_wr, r_pq_rd, r_pq_wr;
  logic [31:0]   r_fifo_pc [DEPTH];
  logic [31:0]   r_fifo_w  [DEPTH];
  logic [31:0]   r_pq      [DEPTH];

  logic          w_fifo_ne, w_rsp_live, w_byp, w_pop, w_push, w_free, w_acc;
  logic [CW:0]   w_used;
  logic          w_unused;

  assign w_unused   = ^redirect_pc[1:0];
  assign w_fifo_ne  = (r_cnt != '0);
  assign w_rsp_live = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
`ifdef SMOL_FETCH_BYPASS_EN
  assign w_byp      = w_rsp_live && !w_fifo_ne;
`else
  assign w_byp      = 1'b0;
`endif

  assign instr_valid = w_fifo_ne || w_byp;
  assign instr       = w_byp ? imem_rsp_data  : r_fifo_w[r_rd];
  assign instr_pc    = w_byp ? r_pq[r_pq_rd]  : r_fifo_pc[r_rd];

  assign w_pop  = w_fifo_ne && instr_ready;
  assign w_push = w_rsp_live && !(w_byp && instr_ready);
  assign w_free = w_pop || (w_byp && instr_ready);

  // A slot leaving the FIFO this cycle is a usable credit, so L=1 / DEPTH=2 streams at full rate.
  assign w_used         = {1'b0, r_inflight} + {1'b0, r_cnt};
  assign imem_req_valid = r_run && !redirect_valid &&
                          ((w_used < DEPTH_C) || ((w_used == DEPTH_C) && w_free));
  assign imem_req_addr  = r_fetch_pc;
  assign w_acc          = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_pq_rd    <= '0;
      r_pq_wr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i] <= '0;
        r_fifo_w[i]  <= '0;
        r_pq[i]      <= '0;
      end
    end else begin
      r_run      <= 1'b1;
      r_inflight <= r_inflight + CW'(w_acc) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        // Everything still outstanding after this cycle is stale, including earlier drops.
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_drop     <= r_inflight - CW'(imem_rsp_valid);
        r_cnt      <= '0;
        r_rd       <= '0;
        r_wr       <= '0;
        r_pq_rd    <= '0;
        r_pq_wr    <= '0;
      end else begin
        if (w_acc) begin
          r_fetch_pc     <= r_fetch_pc + 32'd4;
          r_pq[r_pq_wr]  <= r_fetch_pc;
          r_pq_wr        <= r_pq_wr + 1'b1;
        end
        if (imem_rsp_valid && (r_drop != '0))
          r_drop <= r_drop - 1'b1;
        if (w_rsp_live)
          r_pq_rd <= r_pq_rd + 1'b1;
        if (w_push) begin
          r_fifo_pc[r_wr] <= r_pq[r_pq_rd];
          r_fifo_w[r_wr]  <= imem_rsp_data;
          r_wr            <= r_wr + 1'b1;
        end
        if (w_pop)
          r_rd <= r_rd + 1'b1;
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (w_push && !w_pop) |-> (r_cnt != CW'(DEPTH)));

endmodule
